// File: rtl/mem_pkg.sv
// Shared types and defaults for the backing-memory controller.
// Widths here match the cache-side command fields.
package mem_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 8;
  localparam int LATENCY_DEF  = 3;
  localparam int CACHE_TAG_W  = ADDR_W_DEF;
  localparam int CACHE_DATA_W = DATA_W_DEF;

  typedef enum logic [2:0] {
    IDLE,
    WB_WAIT,
    WB_WRITE,
    ACC_WAIT,
    ACCESS,
    RESP
  } state_t;

  function automatic int cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port RAM, synchronous write and read.
// Power-up contents read back as RAM[a] = a.
module ram_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] key;

  // Cells hold data XOR address, so an all-zero power-up reads as RAM[a] = a.
  assign key = DATA_W'(addr_i);

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i ^ key;
    if (re_i) rdata_q <= mem_q[addr_i] ^ key;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Backing-memory controller: optional dirty write-back, then
// a latency-delayed store or refill read with a done pulse.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = CACHE_TAG_W,
  parameter int DATA_W  = CACHE_DATA_W,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              evict_valid,
  input  logic [ADDR_W-1:0] evict_addr,
  input  logic [DATA_W-1:0] evict_data,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_access_done,
  output logic              busy
);

  localparam int CW = cnt_w(LATENCY);
  localparam bit NO_WAIT = (LATENCY == 0);
  localparam logic [CW-1:0] LAST =
    CW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] eaddr_q;
  logic [DATA_W-1:0] edata_q;

  logic              accept;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic [DATA_W-1:0] resp_val;

  assign accept   = (state_q == IDLE) && cmd_valid;
  assign resp_val = we_q ? wdata_q : ram_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rsp_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      eaddr_q <= '0;
      edata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
      if (accept) begin
        we_q    <= cmd_we;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        eaddr_q <= evict_addr;
        edata_q <= evict_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (evict_valid)
            state_d = NO_WAIT ? WB_WRITE : WB_WAIT;
          else
            state_d = NO_WAIT ? ACCESS : ACC_WAIT;
        end
      end
      WB_WAIT: begin
        if (cnt_q == LAST) state_d = WB_WRITE;
        else cnt_d = cnt_q + CW'(1);
      end
      WB_WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = eaddr_q;
        ram_wdata = edata_q;
        cnt_d     = '0;
        state_d   = NO_WAIT ? ACCESS : ACC_WAIT;
      end
      ACC_WAIT: begin
        if (cnt_q == LAST) state_d = ACCESS;
        else cnt_d = cnt_q + CW'(1);
      end
      ACCESS: begin
        ram_we  = we_q;
        ram_re  = !we_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_d   = resp_val;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign mem_access_done = (state_q == RESP);
  assign rsp_data        = (state_q == RESP) ? resp_val : rsp_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl against a behavioural
// memory model with per-command response timing.
module tb_mem_ctrl;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          evict_valid = 1'b0;
  logic [AW-1:0] evict_addr = '0;
  logic [DW-1:0] evict_data = '0;
  logic [DW-1:0] rsp_data;
  logic          mem_access_done;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ram_m [2**AW];

  mem_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .LATENCY (LAT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_we          (cmd_we),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .evict_valid     (evict_valid),
    .evict_addr      (evict_addr),
    .evict_data      (evict_data),
    .rsp_data        (rsp_data),
    .mem_access_done (mem_access_done),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // Model: apply eviction, then the command; timing counts the edge
  // on which the done pulse is sampled, relative to acceptance.
  task automatic issue(
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] wd,
    input  logic          ev,
    input  logic [AW-1:0] ea,
    input  logic [DW-1:0] ed,
    output logic [DW-1:0] exp,
    output int            edges
  );
    if (ev) ram_m[ea] = ed;
    if (we) begin
      ram_m[a] = wd;
      exp = wd;
    end else begin
      exp = ram_m[a];
    end
    edges = ev ? 2 * LAT + 3 : LAT + 2;
    cmd_we      = we;
    cmd_addr    = a;
    cmd_wdata   = wd;
    evict_valid = ev;
    evict_addr  = ea;
    evict_data  = ed;
    cmd_valid   = 1'b1;
  endtask

  task automatic scramble();
    cmd_we      = 1'($urandom);
    cmd_addr    = AW'($urandom);
    cmd_wdata   = DW'($urandom);
    evict_valid = 1'($urandom);
    evict_addr  = AW'($urandom);
    evict_data  = DW'($urandom);
  endtask

  task automatic wait_accept(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready === 1'b1) begin
        @(posedge clock);
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s accept: cmd_ready=%b, required 1", nm, cmd_ready);
    end
  endtask

  task automatic wait_done(
    input int            edges,
    input logic [DW-1:0] exp,
    input string         nm
  );
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < edges + 8) begin
      @(posedge clock);
      #1;
      n++;
      if (mem_access_done === 1'b1) begin
        got = 1'b1;
        n_cmp++;
        if (n + 1 != edges) begin
          n_bad++;
          $display("FAIL %s latency: got %0d, required %0d", nm, n + 1, edges);
        end
        n_cmp++;
        if (rsp_data !== exp) begin
          n_bad++;
          $display("FAIL %s data: got %h, required %h", nm, rsp_data, exp);
        end
      end else begin
        n_cmp++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL %s busy: busy=%b ready=%b, required 1/0", nm, busy, cmd_ready);
        end
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no done within %0d edges, required %0d", nm, n, edges);
    end else begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (mem_access_done !== 1'b0 || cmd_ready !== 1'b1 ||
          busy !== 1'b0 || rsp_data !== exp) begin
        n_bad++;
        $display("FAIL %s after: done=%b ready=%b busy=%b data=%h, required 0/1/0/%h",
                 nm, mem_access_done, cmd_ready, busy, rsp_data, exp);
      end
    end
  endtask

  task automatic run_cmd(
    input logic          we,
    input logic [AW-1:0] a,
    input logic [DW-1:0] wd,
    input logic          ev,
    input logic [AW-1:0] ea,
    input logic [DW-1:0] ed,
    input string         nm
  );
    logic [DW-1:0] exp;
    int edges;
    bit ok;
    issue(we, a, wd, ev, ea, ed, exp, edges);
    wait_accept(nm, ok);
    if (ok) begin
      #1;
      scramble();
      cmd_valid = 1'b0;
      wait_done(edges, exp, nm);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 ||
        mem_access_done !== 1'b0 || rsp_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset: ready=%b busy=%b done=%b data=%h, required 1/0/0/00",
               cmd_ready, busy, mem_access_done, rsp_data);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_refill();
    run_cmd(1'b0, 5'd5, 8'h00, 1'b0, 5'd0, 8'h00, "refill5");
  endtask

  task automatic test_store_refill();
    run_cmd(1'b1, 5'd9, 8'hAB, 1'b0, 5'd0, 8'h00, "store9");
    run_cmd(1'b0, 5'd9, 8'h00, 1'b0, 5'd0, 8'h00, "refill9");
  endtask

  task automatic test_evict();
    run_cmd(1'b0, 5'd3, 8'h00, 1'b1, 5'd20, 8'h6E, "evict_refill3");
    run_cmd(1'b0, 5'd20, 8'h00, 1'b0, 5'd0, 8'h00, "refill20");
  endtask

  task automatic test_evict_same();
    run_cmd(1'b0, 5'd12, 8'h00, 1'b1, 5'd12, 8'h5A, "evict_same12");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_a, exp_b;
    int edges_a, edges_b;
    bit ok;
    issue(1'b1, 5'd17, 8'hC3, 1'b0, 5'd0, 8'h00, exp_a, edges_a);
    wait_accept("b2b_a", ok);
    if (ok) begin
      #1;
      issue(1'b0, 5'd17, 8'h00, 1'b1, 5'd2, 8'h99, exp_b, edges_b);
      wait_done(edges_a, exp_a, "b2b_a");
      @(posedge clock);
      #1;
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b accept: busy=%b one cycle after RESP, required 1", busy);
      end
      scramble();
      cmd_valid = 1'b0;
      wait_done(edges_b, exp_b, "b2b_b");
      run_cmd(1'b0, 5'd2, 8'h00, 1'b0, 5'd0, 8'h00, "b2b_evicted");
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    cmd_we      = 1'b0;
    cmd_addr    = 5'd4;
    cmd_wdata   = 8'h00;
    evict_valid = 1'b1;
    evict_addr  = 5'd7;
    evict_data  = 8'hFF;
    cmd_valid   = 1'b1;
    wait_accept("rst_mid", ok);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 ||
        mem_access_done !== 1'b0 || rsp_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_mid outputs: ready=%b busy=%b done=%b data=%h, required 1/0/0/00",
               cmd_ready, busy, mem_access_done, rsp_data);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      n_cmp++;
      if (mem_access_done !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid done: got %b in reset, required 0", mem_access_done);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_cmd(1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00, "rst_mid_ram7");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_cmd(1'($urandom), AW'($urandom), DW'($urandom),
              1'($urandom), AW'($urandom), DW'($urandom), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) ram_m[i] = DW'(i);
    test_reset();
    test_refill();
    test_store_refill();
    test_evict();
    test_evict_same();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
